sram_dma: RTL and testbench
===========================

Name: sram_dma

Overview:
- Single-channel DMA copy engine between the CPU controller's SRAM port and the SRAM; copies a block of words from `src` to `dst`.
- Muxes CPU and DMA accesses onto the one SRAM port. The CPU always has priority; DMA uses only cycles where the CPU does not assert enable.
- The CPU controller connects to the `cpu_*` ports unchanged. The SRAM connects to the `sram_*` ports.

Parameters:
- ADDR_W, 16, SRAM word-address width
- DATA_W, 32, SRAM data width
- LEN_W, 16, transfer-length width (words)

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- cpu_sram_addr  input  ADDR_W  CPU address
- cpu_sram_di  input  DATA_W  CPU write data
- cpu_sram_en  input  1  CPU access enable
- cpu_sram_we  input  1  CPU write enable
- cpu_sram_do  output  DATA_W  read data to CPU
- sram_addr  output  ADDR_W  SRAM address
- sram_di  output  DATA_W  SRAM write data
- sram_en  output  1  SRAM enable
- sram_we  output  1  SRAM write enable
- sram_do  input  DATA_W  SRAM read data, valid the cycle after a read enable
- dma_start  input  1  start pulse, sampled in IDLE only
- dma_src  input  ADDR_W  source base, sampled with start
- dma_dst  input  ADDR_W  destination base, sampled with start
- dma_len  input  LEN_W  word count, sampled with start
- dma_busy  output  1  transfer in progress
- dma_done  output  1  one-cycle completion pulse
- dma_remaining  output  LEN_W  words not yet written

Behaviour:
- Reset:
  - State IDLE.
  - `dma_busy`=0, `dma_done`=0, `dma_remaining`=0.
  - Address, length and buffer registers cleared.
  - `sram_en`/`sram_we` follow the CPU only.
  - Reset mid-transfer aborts the copy with no further SRAM access and no done pulse. Words already written stay written.
- SRAM mux (combinational):
  - If `cpu_sram_en`=1, pass the CPU addr/di/en/we straight through.
  - Otherwise drive the DMA request, if the current state issues one; else en=0, we=0.
  - `cpu_sram_do` = `sram_do` always.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE.
- IDLE:
  - `dma_start`=1 latches src/dst/len.
  - If len≠0, go to RD_REQ with `busy`=1 and `remaining`=len.
  - If len=0, go to DONE with no SRAM access.
- RD_REQ:
  - DMA requests en=1, we=0, addr=src.
  - If `cpu_sram_en`=1, stall in RD_REQ.
  - Else the request is granted; go to RD_WAIT.
- RD_WAIT:
  - Capture `sram_do` into the 1-word buffer; go to WR_REQ.
  - No DMA request in this cycle; a CPU access here is legal and does not disturb the capture.
- WR_REQ:
  - DMA requests en=1, we=1, addr=dst, di=buffer.
  - Stall while `cpu_sram_en`=1.
  - On grant: src+1, dst+1 (both mod 2^ADDR_W, wrap 0xFFFF→0x0000), remaining−1.
  - If remaining becomes 0, go to DONE; else go to RD_REQ.
- DONE:
  - `dma_done`=1 for exactly this cycle, `busy`=0; go to IDLE.
  - A start in the DONE cycle is ignored.
- Start rules: `dma_start` while busy is ignored, with no register change.
- Throughput: 3 cycles/word with no CPU contention. Latency from start to done = 3·len+1 cycles uncontended.
- Overlap: strictly ascending word-by-word copy, each read completing before its write. dst>src overlap therefore replicates data; this is defined behaviour, not an error.
- CPU/DMA same address, same cycle: the CPU wins and the DMA stalls, so there is never a write collision.

Decomposition:
- DMA state encodings (`DMA_STATE_IDLE`..`DMA_STATE_DONE`, 3-bit) go in the shared `defines.vh` next to the `CTL_STATE_*` encodings.
- Natural sub-module: `sram_port_mux`, the combinational CPU-priority mux. The FSM and counters stay in `sram_dma`.

Test Plan:
- Memory preload 0x100..0x103 = 11,22,33,44; start src=0x100 dst=0x200 len=4, CPU idle → 0x200..0x203 = 11,22,33,44; `dma_done` exactly 13 cycles after start; `remaining` steps 4→0.
- Same copy with `cpu_sram_en` held 1 for 5 cycles during RD_REQ → DMA stalls exactly 5 cycles, CPU reads return correct data, final memory identical, done 5 cycles late.
- start len=0 → `dma_done` on the next cycle, `sram_en` never asserted by DMA, `busy` stays 0.
- src=0xFFFE dst=0x0010 len=3 → copies words 0xFFFE, 0xFFFF, 0x0000 to 0x10..0x12 (address wrap).
- Second `dma_start` (src=0x300) pulsed mid-transfer → ignored; original transfer completes unchanged.
- reset asserted in WR_REQ after 2 of 4 words → `busy`=0, no done pulse, only 0x200/0x201 written, no further SRAM writes.

Source files
------------

// File: rtl/sram_dma_pkg.sv
// Shared types for the SRAM DMA copy engine.
package sram_dma_pkg;

    typedef enum logic [2:0] {
        DMA_STATE_IDLE    = 3'd0,
        DMA_STATE_RD_REQ  = 3'd1,
        DMA_STATE_RD_WAIT = 3'd2,
        DMA_STATE_WR_REQ  = 3'd3,
        DMA_STATE_DONE    = 3'd4
    } dma_state_e;

endpackage

// File: rtl/sram_port_mux.sv
// CPU-priority multiplexer onto the single SRAM port; DMA only gets idle CPU cycles.
module sram_port_mux
    import sram_dma_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32
) (
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_di_i,
    input  logic              cpu_en_i,
    input  logic              cpu_we_i,
    input  logic              dma_req_i,
    input  logic              dma_we_i,
    input  logic [ADDR_W-1:0] dma_addr_i,
    input  logic [DATA_W-1:0] dma_di_i,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [DATA_W-1:0] sram_di_o,
    output logic              sram_en_o,
    output logic              sram_we_o,
    output logic              dma_grant_o
);

    always_comb begin
        sram_addr_o = dma_addr_i;
        sram_di_o   = dma_di_i;
        sram_en_o   = dma_req_i;
        sram_we_o   = dma_req_i & dma_we_i;
        dma_grant_o = dma_req_i & ~cpu_en_i;
        if (cpu_en_i) begin
            sram_addr_o = cpu_addr_i;
            sram_di_o   = cpu_di_i;
            sram_en_o   = 1'b1;
            sram_we_o   = cpu_we_i;
        end
    end

endmodule

// File: rtl/sram_dma.sv
// Single-channel word-copy DMA sharing the SRAM port with the CPU controller.
module sram_dma
    import sram_dma_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_sram_addr,
    input  logic [DATA_W-1:0] cpu_sram_di,
    input  logic              cpu_sram_en,
    input  logic              cpu_sram_we,
    output logic [DATA_W-1:0] cpu_sram_do,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_di,
    output logic              sram_en,
    output logic              sram_we,
    input  logic [DATA_W-1:0] sram_do,
    input  logic              dma_start,
    input  logic [ADDR_W-1:0] dma_src,
    input  logic [ADDR_W-1:0] dma_dst,
    input  logic [LEN_W-1:0]  dma_len,
    output logic              dma_busy,
    output logic              dma_done,
    output logic [LEN_W-1:0]  dma_remaining
);

    dma_state_e        state_q;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [LEN_W-1:0]  rem_q;
    logic [DATA_W-1:0] buf_q;
    logic              busy_q;
    logic              done_q;

    logic              dma_req;
    logic              dma_we;
    logic              dma_grant;

    // Reset masks the request combinationally so an abort never lands one more access.
    assign dma_req = ~reset & ((state_q == DMA_STATE_RD_REQ) | (state_q == DMA_STATE_WR_REQ));
    assign dma_we  = (state_q == DMA_STATE_WR_REQ);

    sram_port_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mux (
        .cpu_addr_i  (cpu_sram_addr),
        .cpu_di_i    (cpu_sram_di),
        .cpu_en_i    (cpu_sram_en),
        .cpu_we_i    (cpu_sram_we),
        .dma_req_i   (dma_req),
        .dma_we_i    (dma_we),
        .dma_addr_i  (dma_we ? dst_q : src_q),
        .dma_di_i    (buf_q),
        .sram_addr_o (sram_addr),
        .sram_di_o   (sram_di),
        .sram_en_o   (sram_en),
        .sram_we_o   (sram_we),
        .dma_grant_o (dma_grant)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= DMA_STATE_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            buf_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                DMA_STATE_IDLE: begin
                    if (dma_start) begin
                        src_q <= dma_src;
                        dst_q <= dma_dst;
                        rem_q <= dma_len;
                        if (dma_len != '0) begin
                            busy_q  <= 1'b1;
                            state_q <= DMA_STATE_RD_REQ;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= DMA_STATE_DONE;
                        end
                    end
                end
                DMA_STATE_RD_REQ: begin
                    if (dma_grant) state_q <= DMA_STATE_RD_WAIT;
                end
                DMA_STATE_RD_WAIT: begin
                    buf_q   <= sram_do;
                    state_q <= DMA_STATE_WR_REQ;
                end
                DMA_STATE_WR_REQ: begin
                    if (dma_grant) begin
                        src_q <= src_q + ADDR_W'(1);
                        dst_q <= dst_q + ADDR_W'(1);
                        rem_q <= rem_q - LEN_W'(1);
                        if (rem_q == LEN_W'(1)) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DMA_STATE_DONE;
                        end else begin
                            state_q <= DMA_STATE_RD_REQ;
                        end
                    end
                end
                DMA_STATE_DONE: state_q <= DMA_STATE_IDLE;
                default:        state_q <= DMA_STATE_IDLE;
            endcase
        end
    end

    assign cpu_sram_do   = sram_do;
    assign dma_busy      = busy_q;
    assign dma_done      = done_q;
    assign dma_remaining = rem_q;

endmodule

// File: tb/tb_sram_dma.sv
// Self-checking bench for sram_dma: SRAM model, slot-based timing model, random copies.
module tb_sram_dma;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] cpu_sram_addr;
    logic [DW-1:0] cpu_sram_di;
    logic          cpu_sram_en;
    logic          cpu_sram_we;
    logic [DW-1:0] cpu_sram_do;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_di;
    logic          sram_en;
    logic          sram_we;
    logic [DW-1:0] sram_do;
    logic          dma_start;
    logic [AW-1:0] dma_src;
    logic [AW-1:0] dma_dst;
    logic [LW-1:0] dma_len;
    logic          dma_busy;
    logic          dma_done;
    logic [LW-1:0] dma_remaining;

    always #5 clk = ~clk;

    sram_dma #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk           (clk),
        .reset         (reset),
        .cpu_sram_addr (cpu_sram_addr),
        .cpu_sram_di   (cpu_sram_di),
        .cpu_sram_en   (cpu_sram_en),
        .cpu_sram_we   (cpu_sram_we),
        .cpu_sram_do   (cpu_sram_do),
        .sram_addr     (sram_addr),
        .sram_di       (sram_di),
        .sram_en       (sram_en),
        .sram_we       (sram_we),
        .sram_do       (sram_do),
        .dma_start     (dma_start),
        .dma_src       (dma_src),
        .dma_dst       (dma_dst),
        .dma_len       (dma_len),
        .dma_busy      (dma_busy),
        .dma_done      (dma_done),
        .dma_remaining (dma_remaining)
    );

    // Synchronous SRAM: read data appears the cycle after a read enable.
    logic [DW-1:0] mem     [0:65535];
    logic [DW-1:0] ref_mem [0:65535];
    logic [DW-1:0] rdata = '0;
    int            dma_acc = 0;
    int            n_checks = 0;
    int            n_fail = 0;

    assign sram_do = rdata;

    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we) mem[sram_addr] <= sram_di;
            else         rdata <= mem[sram_addr];
        end
        if (sram_en && !cpu_sram_en) dma_acc <= dma_acc + 1;
    end

    task automatic put(input logic [AW-1:0] a, input logic [DW-1:0] v);
        mem[a] <= v;
        ref_mem[a] = v;
    endtask

    // mode 0: CPU idle, 1: CPU reads during cycles 1..5, 2: random CPU reads.
    task automatic run_copy(input logic [AW-1:0] src, input logic [AW-1:0] dst,
                            input logic [LW-1:0] len, input int mode, input bit restart,
                            output int done_obs, output int done_exp);
        bit            pat [512];
        int            wr_t [$];
        int            t;
        int            cnt;
        bit            rd_pend;
        logic [DW-1:0] rd_exp;
        logic          exp_busy;
        logic [LW-1:0] exp_rem;
        for (int k = 0; k < 512; k++) pat[k] = 1'b0;
        if (mode == 1) for (int k = 1; k <= 5; k++) pat[k] = 1'b1;
        if (mode == 2) for (int k = 1; k < 512; k++) pat[k] = ($urandom_range(0, 99) < 35);
        // Each word: first free cycle reads, one cycle waits, next free cycle writes.
        t = 1;
        for (int i = 0; i < int'(len); i++) begin
            while (t < 500 && pat[t]) t++;
            t += 2;
            while (t < 500 && pat[t]) t++;
            wr_t.push_back(t);
            t++;
        end
        done_exp = t;
        done_obs = 0;
        rd_pend  = 1'b0;
        rd_exp   = '0;

        @(negedge clk);
        dma_src   = src;
        dma_dst   = dst;
        dma_len   = len;
        dma_start = 1'b1;
        cpu_sram_en = 1'b0;
        for (int k = 1; k <= done_exp + 1; k++) begin
            @(negedge clk);
            if (k == 1) dma_start = 1'b0;
            if (rd_pend) begin
                n_checks++;
                if (cpu_sram_do !== rd_exp) begin
                    n_fail++;
                    $display("FAIL cpu_read k=%0d: got %h expected %h", k, cpu_sram_do, rd_exp);
                end
                rd_pend = 1'b0;
            end
            exp_busy = (len != 0) && (k < done_exp);
            cnt = 0;
            foreach (wr_t[i]) if (wr_t[i] < k) cnt++;
            exp_rem = len - LW'(cnt);
            n_checks++;
            if (dma_busy !== exp_busy) begin
                n_fail++;
                $display("FAIL busy k=%0d: got %b expected %b", k, dma_busy, exp_busy);
            end
            n_checks++;
            if (dma_remaining !== exp_rem) begin
                n_fail++;
                $display("FAIL remaining k=%0d: got %0d expected %0d", k, dma_remaining, exp_rem);
            end
            n_checks++;
            if (dma_done !== (k == done_exp)) begin
                n_fail++;
                $display("FAIL done_pulse k=%0d: got %b expected %b", k, dma_done, (k == done_exp));
            end
            if (dma_done === 1'b1 && done_obs == 0) done_obs = k;
            if (restart && k == 4) begin
                dma_src   = 16'h0300;
                dma_dst   = 16'h0400;
                dma_len   = 16'd2;
                dma_start = 1'b1;
            end else if (restart && k == 5) begin
                dma_start = 1'b0;
            end
            if (k < done_exp && pat[k]) begin
                cpu_sram_en   = 1'b1;
                cpu_sram_we   = 1'b0;
                cpu_sram_addr = (mode == 1) ? src + AW'(k % 4) : 16'h7000 + AW'(k);
                rd_exp        = ref_mem[cpu_sram_addr];
                rd_pend       = 1'b1;
            end else begin
                cpu_sram_en = 1'b0;
            end
        end
        cpu_sram_en = 1'b0;
        for (int i = 0; i < int'(len); i++)
            ref_mem[dst + AW'(i)] = ref_mem[src + AW'(i)];
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cpu_sram_en = 1'b0; cpu_sram_we = 1'b0; cpu_sram_addr = '0; cpu_sram_di = '0;
        dma_start = 1'b0; dma_src = '0; dma_dst = '0; dma_len = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (dma_busy !== 1'b0 || dma_done !== 1'b0 || dma_remaining !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b rem=%0d expected 0/0/0",
                     dma_busy, dma_done, dma_remaining);
        end
        n_checks++;
        if (sram_en !== 1'b0 || sram_we !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_sram_idle: got en=%b we=%b expected 0/0", sram_en, sram_we);
        end
        cpu_sram_en = 1'b1; cpu_sram_addr = 16'h1234; cpu_sram_di = 32'hCAFE_F00D;
        #1;
        n_checks++;
        if (sram_en !== 1'b1 || sram_addr !== 16'h1234 || sram_di !== 32'hCAFE_F00D || sram_we !== 1'b0) begin
            n_fail++;
            $display("FAIL cpu_passthru: got en=%b we=%b addr=%h di=%h expected 1/0/1234/cafef00d",
                     sram_en, sram_we, sram_addr, sram_di);
        end
        @(negedge clk);
        cpu_sram_en = 1'b0;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int d, e, acc0;
        logic [DW-1:0] want [4];
        want[0] = 32'd11; want[1] = 32'd22; want[2] = 32'd33; want[3] = 32'd44;
        for (int i = 0; i < 4; i++) begin
            put(16'h0100 + AW'(i), want[i]);
            put(16'h0200 + AW'(i), '0);
        end
        acc0 = dma_acc;
        run_copy(16'h0100, 16'h0200, 16'd4, 0, 1'b0, d, e);
        n_checks++;
        if (d != 13) begin n_fail++; $display("FAIL basic_latency: got %0d expected 13", d); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (mem[16'h0200 + AW'(i)] !== want[i]) begin
                n_fail++;
                $display("FAIL basic_data[%0d]: got %0d expected %0d", i, mem[16'h0200 + AW'(i)], want[i]);
            end
        end
        n_checks++;
        if (dma_acc - acc0 != 8) begin n_fail++; $display("FAIL basic_accesses: got %0d expected 8", dma_acc - acc0); end
    endtask

    task automatic test_cpu_stall();
        int d, e;
        for (int i = 0; i < 4; i++) begin
            put(16'h0100 + AW'(i), 32'd11 * (i + 1));
            put(16'h0200 + AW'(i), '0);
        end
        run_copy(16'h0100, 16'h0200, 16'd4, 1, 1'b0, d, e);
        n_checks++;
        if (d != 18) begin n_fail++; $display("FAIL stall_latency: got %0d expected 18", d); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (mem[16'h0200 + AW'(i)] !== 32'(11 * (i + 1))) begin
                n_fail++;
                $display("FAIL stall_data[%0d]: got %0d expected %0d", i, mem[16'h0200 + AW'(i)], 11 * (i + 1));
            end
        end
    endtask

    task automatic test_zero_len();
        int d, e, acc0;
        acc0 = dma_acc;
        run_copy(16'h0100, 16'h0500, 16'd0, 0, 1'b0, d, e);
        n_checks++;
        if (d != 1) begin n_fail++; $display("FAIL zero_len_done: got %0d expected 1", d); end
        n_checks++;
        if (dma_acc != acc0) begin n_fail++; $display("FAIL zero_len_access: got %0d expected 0", dma_acc - acc0); end
    endtask

    task automatic test_wrap();
        int d, e;
        logic [DW-1:0] v [3];
        logic [AW-1:0] sa [3];
        sa[0] = 16'hFFFE; sa[1] = 16'hFFFF; sa[2] = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            v[i] = $urandom;
            put(sa[i], v[i]);
            put(16'h0010 + AW'(i), '0);
        end
        run_copy(16'hFFFE, 16'h0010, 16'd3, 0, 1'b0, d, e);
        n_checks++;
        if (d != 10) begin n_fail++; $display("FAIL wrap_latency: got %0d expected 10", d); end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (mem[16'h0010 + AW'(i)] !== v[i]) begin
                n_fail++;
                $display("FAIL wrap_data[%0d]: got %h expected %h", i, mem[16'h0010 + AW'(i)], v[i]);
            end
        end
    endtask

    task automatic test_restart_ignored();
        int d, e;
        logic [DW-1:0] v [4];
        for (int i = 0; i < 4; i++) begin
            v[i] = $urandom;
            put(16'h0100 + AW'(i), v[i]);
            put(16'h0200 + AW'(i), '0);
            put(16'h0300 + AW'(i), 32'hBAD0_0000 + i);
            put(16'h0400 + AW'(i), 32'h5E47_0000 + i);
        end
        run_copy(16'h0100, 16'h0200, 16'd4, 0, 1'b1, d, e);
        n_checks++;
        if (d != 13) begin n_fail++; $display("FAIL restart_latency: got %0d expected 13", d); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (mem[16'h0200 + AW'(i)] !== v[i] || mem[16'h0400 + AW'(i)] !== 32'h5E47_0000 + i) begin
                n_fail++;
                $display("FAIL restart_data[%0d]: got %h/%h expected %h/%h", i,
                         mem[16'h0200 + AW'(i)], mem[16'h0400 + AW'(i)], v[i], 32'h5E47_0000 + i);
            end
        end
    endtask

    task automatic test_reset_abort();
        int acc0, dones;
        logic [DW-1:0] v [4];
        for (int i = 0; i < 4; i++) begin
            v[i] = $urandom;
            put(16'h0100 + AW'(i), v[i]);
            put(16'h0200 + AW'(i), 32'hDEAD_0000 + i);
        end
        @(negedge clk);
        acc0 = dma_acc;
        dma_src = 16'h0100; dma_dst = 16'h0200; dma_len = 16'd4; dma_start = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            dma_start = 1'b0;
        end
        n_checks++;
        if (dma_remaining !== 16'd2 || dma_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_precondition: got rem=%0d busy=%b expected 2/1", dma_remaining, dma_busy);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        dones = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (dma_done === 1'b1 || dma_busy !== 1'b0) dones++;
        end
        n_checks++;
        if (dones != 0) begin n_fail++; $display("FAIL abort_quiet: got %0d busy/done cycles expected 0", dones); end
        n_checks++;
        if (dma_acc - acc0 != 5) begin n_fail++; $display("FAIL abort_accesses: got %0d expected 5", dma_acc - acc0); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (mem[16'h0200 + AW'(i)] !== ((i < 2) ? v[i] : 32'hDEAD_0000 + i)) begin
                n_fail++;
                $display("FAIL abort_data[%0d]: got %h expected %h", i, mem[16'h0200 + AW'(i)],
                         (i < 2) ? v[i] : 32'hDEAD_0000 + i);
            end
        end
    endtask

    task automatic test_random();
        int d, e;
        logic [AW-1:0] src, dst;
        logic [LW-1:0] len;
        for (int a = 0; a < 512; a++) put(16'h7000 + AW'(a), $urandom);
        for (int it = 0; it < 8; it++) begin
            src = 16'h1000 + AW'($urandom_range(0, 16'h0F00));
            dst = ($urandom_range(0, 1) == 1) ? src + AW'($urandom_range(0, 4))
                                              : 16'h1000 + AW'($urandom_range(0, 16'h0F00));
            len = LW'($urandom_range(1, 12));
            for (int i = -2; i < int'(len) + 2; i++) begin
                put(src + AW'(i), $urandom);
                put(dst + AW'(i), $urandom);
            end
            run_copy(src, dst, len, 2, 1'b0, d, e);
            n_checks++;
            if (d != e) begin n_fail++; $display("FAIL rand_latency it=%0d: got %0d expected %0d", it, d, e); end
            for (int i = -1; i <= int'(len); i++) begin
                n_checks++;
                if (mem[dst + AW'(i)] !== ref_mem[dst + AW'(i)]) begin
                    n_fail++;
                    $display("FAIL rand_data it=%0d addr=%h: got %h expected %h", it, dst + AW'(i),
                             mem[dst + AW'(i)], ref_mem[dst + AW'(i)]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_cpu_stall();
        test_zero_len();
        test_wrap();
        test_restart_ignored();
        test_reset_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
